// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
//   Writes one received UART pixel row into the single-port frame RAM and
//   shares that RAM's address port with the VGA pixel reader. Reads win by
//   default; after MAX_STARVE consecutive denied write cycles the next cycle
//   is a forced write slot, so a row always completes.
//
// Ports
//   clk, rst          : single clock, synchronous active-high reset
//   row_valid/ready   : row handshake; row_index + row_data latched on accept
//   row_done          : one-cycle pulse after the last pixel of a row is written
//   row_error         : one-cycle pulse when row_index >= HEIGHT (row dropped)
//   busy              : a row is being checked / written / finished
//   rd_req, rd_addr   : VGA read request
//   rd_grant          : read presented on ram_addr this cycle
//   rd_data_valid     : ram_q holds data for a granted read (RAM_LATENCY later)
//   ram_addr/wdata/wren : registered RAM port
module fb_port_arbiter #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int PIX_BITS    = 3,
    parameter int ADDR_WIDTH  = 19,
    parameter int RAM_LATENCY = 2,
    parameter int MAX_STARVE  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      row_valid,
    output logic                      row_ready,
    input  logic [8:0]                row_index,
    input  logic [PIX_BITS*WIDTH-1:0] row_data,
    output logic                      row_done,
    output logic                      row_error,
    output logic                      busy,
    input  logic                      rd_req,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic                      rd_grant,
    output logic                      rd_data_valid,
    output logic [ADDR_WIDTH-1:0]     ram_addr,
    output logic [PIX_BITS-1:0]       ram_wdata,
    output logic                      ram_wren
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int SW    = $clog2(MAX_STARVE + 1);

    typedef enum logic [1:0] {IDLE, CHECK, WRITE, DONE} state_t;

    state_t                    state_q, state_d;
    logic [PIX_BITS*WIDTH-1:0] shadow_q, shadow_d;
    logic [8:0]                idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]     base_q, base_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [SW-1:0]             starve_q, starve_d;
    logic                      row_done_q, row_done_d;
    logic                      row_error_q, row_error_d;
    logic                      rd_grant_q, rd_grant_d;
    logic [ADDR_WIDTH-1:0]     ram_addr_q, ram_addr_d;
    logic [PIX_BITS-1:0]       ram_wdata_q, ram_wdata_d;
    logic                      ram_wren_q, ram_wren_d;
    logic [RAM_LATENCY-1:0]    vld_pipe_q, vld_pipe_d;

    logic in_write, forced, wr_slot;

    // A forced slot only exists while a row is being written; otherwise
    // every read request is granted.
    assign in_write = (state_q == WRITE);
    assign forced   = in_write && (starve_q == SW'(MAX_STARVE));
    assign wr_slot  = in_write && !(rd_req && !forced);

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        idx_d       = idx_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        row_done_d  = 1'b0;
        row_error_d = 1'b0;

        rd_grant_d  = rd_req && !forced;
        ram_wren_d  = wr_slot;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (rd_grant_d) begin
            ram_addr_d = rd_addr;
        end else if (wr_slot) begin
            ram_addr_d  = base_q + ADDR_WIDTH'(cnt_q);
            ram_wdata_d = shadow_q[PIX_BITS*cnt_q +: PIX_BITS];
        end

        // Counts reads that beat a pending write; any write slot (or leaving
        // WRITE) starts the count over.
        if (!in_write || wr_slot) starve_d = '0;
        else                      starve_d = starve_q + SW'(1);

        // RAM_LATENCY-deep shift of the grant; writes never enter it.
        vld_pipe_d = RAM_LATENCY'({vld_pipe_q, rd_grant_q});

        case (state_q)
            IDLE: begin
                if (row_valid) begin
                    shadow_d = row_data;
                    idx_d    = row_index;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if (32'(idx_q) >= HEIGHT) begin
                    row_error_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    base_d  = ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(WIDTH);
                    cnt_d   = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (wr_slot) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
                end
            end
            DONE: begin
                row_done_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            idx_q       <= '0;
            base_q      <= '0;
            cnt_q       <= '0;
            starve_q    <= '0;
            row_done_q  <= 1'b0;
            row_error_q <= 1'b0;
            rd_grant_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wren_q  <= 1'b0;
            vld_pipe_q  <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            idx_q       <= idx_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            row_done_q  <= row_done_d;
            row_error_q <= row_error_d;
            rd_grant_q  <= rd_grant_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wren_q  <= ram_wren_d;
            vld_pipe_q  <= vld_pipe_d;
        end
    end

    assign row_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign row_done      = row_done_q;
    assign row_error     = row_error_q;
    assign rd_grant      = rd_grant_q;
    assign rd_data_valid = vld_pipe_q[RAM_LATENCY-1];
    assign ram_addr      = ram_addr_q;
    assign ram_wdata     = ram_wdata_q;
    assign ram_wren      = ram_wren_q;

endmodule
